glyph_scroll_rom: RTL and testbench

// - Parametrised bitmap ROM with a built-in row scanner and horizontal scroller for the LED/VGA text banner path.
// - Holds a ROWS x ROW_W monochrome bitmap, for example several 32x32 glyphs placed side by side.
// - Streams one WIN_W-pixel window row per valid/ready transfer to the display driver.
// - Advances a circular horizontal offset every FRAMES_PER_STEP frames, either left or right.

---
 rtl/glyph_scroll_rom.sv | 158 +++++++++++++++
 tb/tb_glyph_scroll_rom.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/glyph_scroll_rom.sv
// ============================================================================
// Module   : glyph_scroll_rom
// Purpose  : Bitmap ROM with a row scanner and a circular horizontal scroller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module glyph_scroll_rom #(
    parameter int                         ROWS            = 32,
    parameter int                         ROW_W           = 128,
    parameter int                         WIN_W           = 32,
    parameter int                         FRAMES_PER_STEP = 4,
    parameter logic [ROWS*ROW_W-1:0]      INIT_DATA       = '0,
    localparam int                        IDX_W           = $clog2(ROWS),
    localparam int                        OFF_W           = $clog2(ROW_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             scroll_en_i,
    input  logic             dir_i,
    input  logic             row_ready_i,
    output logic             row_valid_o,
    output logic [IDX_W-1:0] row_idx_o,
    output logic [WIN_W-1:0] row_data_o,
    output logic [OFF_W-1:0] offset_o,
    output logic             frame_done_o
);

    localparam int               FC_W         = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [IDX_W-1:0] c_LAST_ROW   = IDX_W'(ROWS - 1);
    localparam logic [OFF_W-1:0] c_LAST_COL   = OFF_W'(ROW_W - 1);
    localparam logic [FC_W-1:0]  c_LAST_FRAME = FC_W'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [IDX_W-1:0]   row_idx_q,    row_idx_d;
    logic [WIN_W-1:0]   row_data_q,   row_data_d;
    logic               row_valid_q,  row_valid_d;
    logic [OFF_W-1:0]   offset_q,     offset_d;
    logic [FC_W-1:0]    fc_q,         fc_d;
    logic               stop_q,       stop_d;
    logic               frame_done_q, frame_done_d;

    logic [ROW_W-1:0]   w_rom [ROWS];
    logic [ROW_W-1:0]   w_row;
    logic [2*ROW_W-1:0] w_dbl;
    logic [WIN_W-1:0]   w_win;
    logic               w_stop;

    for (genvar r = 0; r < ROWS; r++) begin : g_rom
        assign w_rom[r] = INIT_DATA[ROWS*ROW_W-1 - r*ROW_W -: ROW_W];
    end

    // Two copies of the row side by side make the circular window a plain slice.
    assign w_row  = w_rom[row_idx_q];
    assign w_dbl  = {w_row, w_row};
    assign w_win  = w_dbl[(2*ROW_W-1) - int'(offset_q) -: WIN_W];
    assign w_stop = stop_q | stop_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_idx_q    <= '0;
            row_data_q   <= '0;
            row_valid_q  <= 1'b0;
            offset_q     <= '0;
            fc_q         <= '0;
            stop_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_idx_q    <= row_idx_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            offset_q     <= offset_d;
            fc_q         <= fc_d;
            stop_q       <= stop_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        row_data_d   = row_data_q;
        row_valid_d  = row_valid_q;
        offset_d     = offset_q;
        fc_d         = fc_q;
        stop_d       = stop_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                row_valid_d = 1'b0;
                if (start_i) begin
                    state_d   = FETCH;
                    row_idx_d = '0;
                    stop_d    = stop_i;
                end
            end
            FETCH: begin
                row_data_d  = w_win;
                row_valid_d = 1'b1;
                stop_d      = w_stop;
                state_d     = SHOW;
            end
            SHOW: begin
                stop_d = w_stop;
                if (row_ready_i) begin
                    row_valid_d = 1'b0;
                    if (row_idx_q != c_LAST_ROW) begin
                        row_idx_d = row_idx_q + 1'b1;
                        state_d   = FETCH;
                    end else begin
                        frame_done_d = 1'b1;
                        row_idx_d    = '0;
                        // Offset only moves here, between frames, so a frame never tears.
                        if (fc_q == c_LAST_FRAME) begin
                            fc_d = '0;
                            if (scroll_en_i) begin
                                if (dir_i) begin
                                    offset_d = (offset_q == '0) ? c_LAST_COL : offset_q - 1'b1;
                                end else begin
                                    offset_d = (offset_q == c_LAST_COL) ? '0 : offset_q + 1'b1;
                                end
                            end
                        end else begin
                            fc_d = fc_q + 1'b1;
                        end
                        if (w_stop) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign row_valid_o  = row_valid_q;
    assign row_idx_o    = row_idx_q;
    assign row_data_o   = row_data_q;
    assign offset_o     = offset_q;
    assign frame_done_o = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_glyph_scroll_rom.sv
// ============================================================================
// Module   : tb_glyph_scroll_rom
// Purpose  : Self-checking bench for glyph_scroll_rom against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_glyph_scroll_rom;

    localparam int ROWS  = 32;
    localparam int ROW_W = 128;
    localparam int WIN_W = 32;
    localparam int FPS   = 4;

    function automatic logic [ROWS*ROW_W-1:0] mk_diag();
        logic [ROWS*ROW_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[ROWS*ROW_W-1 - r*ROW_W - r] = 1'b1;
        return v;
    endfunction

    localparam logic [ROWS*ROW_W-1:0] DIAG = mk_diag();

    logic        clk = 1'b0;
    logic        rst_n, start_i, stop_i, scroll_en_i, dir_i, row_ready_i;
    logic        row_valid_o, frame_done_o;
    logic [4:0]  row_idx_o;
    logic [31:0] row_data_o;
    logic [6:0]  offset_o;

    glyph_scroll_rom #(
        .ROWS            (ROWS),
        .ROW_W           (ROW_W),
        .WIN_W           (WIN_W),
        .FRAMES_PER_STEP (FPS),
        .INIT_DATA       (DIAG)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .scroll_en_i  (scroll_en_i),
        .dir_i        (dir_i),
        .row_ready_i  (row_ready_i),
        .row_valid_o  (row_valid_o),
        .row_idx_o    (row_idx_o),
        .row_data_o   (row_data_o),
        .offset_o     (offset_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame-level view of the scan (running flag, row, bubble, offset).
    bit m_run  = 1'b0;
    bit m_stop = 1'b0;
    bit m_fd   = 1'b0;
    int m_wait = 0;
    int m_row  = 0;
    int m_off  = 0;
    int m_frames = 0;
    int fd_count = 0;
    int dut_fd   = 0;

    function automatic bit m_valid();
        return m_run && (m_wait == 0);
    endfunction

    function automatic logic [31:0] exp_win(input int r, input int off);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < WIN_W; k++)
            if (((off + k) % ROW_W) == r) w[WIN_W-1-k] = 1'b1;
        return w;
    endfunction

    task automatic step(input bit rst, input bit st, input bit sp, input bit rdy,
                        input bit sen, input bit dr);
        rst_n = rst; start_i = st; stop_i = sp; row_ready_i = rdy;
        scroll_en_i = sen; dir_i = dr;
        @(posedge clk);
        m_fd = 1'b0;
        if (!rst) begin
            m_run = 0; m_wait = 0; m_row = 0; m_off = 0; m_frames = 0; m_stop = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1; m_row = 0; m_wait = 1; m_stop = sp;
            end
        end else begin
            if (sp) m_stop = 1'b1;
            if (m_wait > 0) begin
                m_wait--;
            end else if (rdy) begin
                if (m_row < ROWS-1) begin
                    m_row++; m_wait = 1;
                end else begin
                    m_fd = 1'b1; fd_count++; m_frames++; m_row = 0;
                    if ((m_frames % FPS == 0) && sen)
                        m_off = dr ? (m_off + ROW_W - 1) % ROW_W : (m_off + 1) % ROW_W;
                    if (m_stop) begin
                        m_run = 0; m_stop = 0;
                    end else begin
                        m_wait = 1;
                    end
                end
            end
        end
        #1;
        if (frame_done_o) dut_fd++;
        chk_eq("valid",      32'(row_valid_o),  32'(m_valid()));
        chk_eq("row_idx",    32'(row_idx_o),    32'(m_row));
        chk_eq("offset",     32'(offset_o),     32'(m_off));
        chk_eq("frame_done", 32'(frame_done_o), 32'(m_fd));
        if (m_valid()) chk_eq("row_data", row_data_o, exp_win(m_row, m_off));
        if (!rst)      chk_eq("rst_data", row_data_o, 32'h0);
    endtask

    int fd_base, dut_base, saved_off;

    initial begin
        // T1: reset then a one-cycle start
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk_eq("t1_valid_after1", 32'(row_valid_o), 32'h0);
        step(1, 0, 0, 0, 0, 0);
        chk_eq("t1_valid_after2", 32'(row_valid_o), 32'h1);
        chk_eq("t1_data", row_data_o, 32'h8000_0000);

        // T2: backpressure on row 5
        for (int i = 0; i < 200 && !(m_row == 5 && m_valid()); i++) step(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0, 0, 0);
            chk_eq("t2_hold_valid", 32'(row_valid_o), 32'h1);
            chk_eq("t2_hold_data",  row_data_o, 32'h0400_0000);
        end
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_eq("t2_next_idx", 32'(row_idx_o), 32'd6);

        // T3: scroll left over 12 frames
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 0);
        fd_base = fd_count; dut_base = dut_fd;
        for (int i = 0; i < 12*64 + 40 && fd_count < fd_base + 12; i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t3_frames", 32'(dut_fd - dut_base), 32'd12);
        chk_eq("t3_offset", 32'(offset_o), 32'd3);
        for (int i = 0; i < 40 && !(m_row == 5 && m_valid()); i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t3_row5", row_data_o, 32'h2000_0000);

        // T4: wrap at 127 -> 0, then back to 127 scrolling right
        for (int i = 0; i < 40000 && m_off != 127; i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t4_off127", 32'(offset_o), 32'd127);
        for (int i = 0; i < 10 && !(m_row == 0 && m_valid()); i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t4_row0", row_data_o, 32'h4000_0000);
        for (int i = 0; i < 4*64 + 20 && m_off != 0; i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t4_off0", 32'(offset_o), 32'd0);
        fd_base = fd_count;
        for (int i = 0; i < 4*64 + 20 && fd_count < fd_base + 4; i++) step(1, 0, 0, 1, 1, 1);
        chk_eq("t4_right", 32'(offset_o), 32'd127);

        // T5: stop pulsed during row 10
        for (int i = 0; i < 100 && !(m_row == 10 && m_valid()); i++) step(1, 0, 0, 1, 0, 0);
        saved_off = m_off; dut_base = dut_fd;
        step(1, 0, 1, 1, 0, 0);
        for (int i = 0; i < 100 && m_run; i++) step(1, 0, 0, 1, 0, 0);
        chk_eq("t5_fd",     32'(dut_fd - dut_base), 32'd1);
        chk_eq("t5_valid",  32'(row_valid_o), 32'h0);
        chk_eq("t5_offset", 32'(offset_o), 32'(saved_off));
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, 0);
        chk_eq("t5_idle", 32'(row_valid_o), 32'h0);

        // T6: reset in the middle of row 17
        step(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 100 && !(m_row == 17 && m_valid()); i++) step(1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk_eq("t6_valid", 32'(row_valid_o), 32'h0);
        chk_eq("t6_idx",   32'(row_idx_o),   32'h0);
        chk_eq("t6_data",  row_data_o,       32'h0);
        chk_eq("t6_off",   32'(offset_o),    32'h0);
        chk_eq("t6_fd",    32'(frame_done_o), 32'h0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk_eq("t6_restart_idx",  32'(row_idx_o), 32'h0);
        chk_eq("t6_restart_data", row_data_o, 32'h8000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            step(($urandom_range(0, 2999) != 0),
                 (!m_run && ($urandom_range(0, 7) == 0)),
                 ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
